// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one main-memory port between I-cache reads and D-cache reads/writebacks
module mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_res,
  output logic [LINE_SIZE-1:0] i_res_data,
  output logic [WORD_SIZE-1:0] i_res_addr,
  input  logic                 d_read,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic                 d_wenable,
  input  logic [WORD_SIZE-1:0] d_w_addr,
  input  logic [LINE_SIZE-1:0] d_w_data,
  output logic                 d_res,
  output logic [LINE_SIZE-1:0] d_res_data,
  output logic [WORD_SIZE-1:0] d_res_addr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [LINE_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [LINE_SIZE-1:0] mem_rdata
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_BUSY = 1'b1;

  localparam logic [1:0] SRC_I  = 2'd0;
  localparam logic [1:0] SRC_DR = 2'd1;
  localparam logic [1:0] SRC_DW = 2'd2;

  logic                 state;
  logic [1:0]           src;
  logic                 last_grant;

  logic                 i_pend;
  logic [WORD_SIZE-1:0] i_slot_addr;
  logic                 dr_pend;
  logic [WORD_SIZE-1:0] dr_slot_addr;
  logic                 dw_pend;
  logic [WORD_SIZE-1:0] dw_slot_addr;
  logic [LINE_SIZE-1:0] dw_slot_data;

  logic busy;
  logic i_hold, dr_hold, dw_hold;
  logic i_take, dr_take, dw_take;
  logic i_want, dr_want, dw_want, d_want;
  logic pick_d, grant_any, grant_i, grant_dr, grant_dw;
  logic [WORD_SIZE-1:0] i_cur_addr, dr_cur_addr, dw_cur_addr;
  logic [LINE_SIZE-1:0] dw_cur_data;

  assign busy = (state == STATE_BUSY);

  // A slot counts as occupied while its own transaction is in flight, until the ack cycle.
  assign i_hold  = i_pend  | (busy & (src == SRC_I)  & ~mem_ack);
  assign dr_hold = dr_pend | (busy & (src == SRC_DR) & ~mem_ack);
  assign dw_hold = dw_pend | (busy & (src == SRC_DW) & ~mem_ack);

  assign i_take  = i_read    & ~i_hold;
  assign dr_take = d_read    & ~dr_hold;
  assign dw_take = d_wenable & ~dw_hold;

  assign i_want  = i_pend  | i_take;
  assign dr_want = dr_pend | dr_take;
  assign dw_want = dw_pend | dw_take;
  assign d_want  = dr_want | dw_want;

  assign i_cur_addr  = i_pend  ? i_slot_addr  : i_addr;
  assign dr_cur_addr = dr_pend ? dr_slot_addr : d_addr;
  assign dw_cur_addr = dw_pend ? dw_slot_addr : d_w_addr;
  assign dw_cur_data = dw_pend ? dw_slot_data : d_w_data;

  // last_grant = 0 means I went last, so D takes a contested round.
  assign pick_d    = d_want & (~i_want | ~last_grant);
  assign grant_any = ~busy & (i_want | d_want);
  assign grant_i   = grant_any & ~pick_d;
  assign grant_dw  = grant_any & pick_d & dw_want;
  assign grant_dr  = grant_any & pick_d & ~dw_want;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= STATE_IDLE;
      src          <= SRC_I;
      last_grant   <= 1'b0;
      i_pend       <= 1'b0;
      i_slot_addr  <= '0;
      dr_pend      <= 1'b0;
      dr_slot_addr <= '0;
      dw_pend      <= 1'b0;
      dw_slot_addr <= '0;
      dw_slot_data <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_res        <= 1'b0;
      i_res_data   <= '0;
      i_res_addr   <= '0;
      d_res        <= 1'b0;
      d_res_data   <= '0;
      d_res_addr   <= '0;
    end else begin
      mem_req <= 1'b0;
      i_res   <= 1'b0;
      d_res   <= 1'b0;

      if (i_take) i_slot_addr <= i_addr;
      if (dr_take) dr_slot_addr <= d_addr;
      if (dw_take) begin
        dw_slot_addr <= d_w_addr;
        dw_slot_data <= d_w_data;
      end
      i_pend  <= i_want  & ~grant_i;
      dr_pend <= dr_want & ~grant_dr;
      dw_pend <= dw_want & ~grant_dw;

      if (grant_any) begin
        state      <= STATE_BUSY;
        mem_req    <= 1'b1;
        last_grant <= pick_d;
        if (grant_dw) begin
          src       <= SRC_DW;
          mem_we    <= 1'b1;
          mem_addr  <= dw_cur_addr;
          mem_wdata <= dw_cur_data;
        end else if (grant_dr) begin
          src       <= SRC_DR;
          mem_we    <= 1'b0;
          mem_addr  <= dr_cur_addr;
          mem_wdata <= '0;
        end else begin
          src       <= SRC_I;
          mem_we    <= 1'b0;
          mem_addr  <= i_cur_addr;
          mem_wdata <= '0;
        end
      end else if (busy && mem_ack) begin
        state <= STATE_IDLE;
        if (src == SRC_I) begin
          i_res      <= 1'b1;
          i_res_data <= mem_rdata;
          i_res_addr <= mem_addr;
        end else if (src == SRC_DR) begin
          d_res      <= 1'b1;
          d_res_data <= mem_rdata;
          d_res_addr <= mem_addr;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the instruction-cache miss path (`i_read`) and the data-cache miss and writeback paths (`d_read`, `d_wenable`) of `core`. Each request is latched into a per-source pending slot, and one memory transaction is issued at a time. The response is routed back to the requesting cache. The block sits between `core` and the memory model in the top-level testbench/SoC.

## Interface
- `WORD_SIZE`, 32, address width.
- `LINE_SIZE`, 128, cache line width in bits.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_read` in 1: I-cache line read request. One-cycle pulse is sufficient.
- `i_addr` in WORD_SIZE: I-cache request address, sampled with `i_read`.
- `i_res` out 1: one-cycle pulse, I line returned.
- `i_res_data` out LINE_SIZE: returned I line.
- `i_res_addr` out WORD_SIZE: address of the returned I line.
- `d_read` in 1: D-cache line read request.
- `d_addr` in WORD_SIZE: D read address.
- `d_wenable` in 1: D-cache line write (writeback) request.
- `d_w_addr` in WORD_SIZE: write address.
- `d_w_data` in LINE_SIZE: write data.
- `d_res` out 1: one-cycle pulse, D read line returned.
- `d_res_data` out LINE_SIZE: returned D line.
- `d_res_addr` out WORD_SIZE: address of the returned D line.
- `mem_req` out 1: one-cycle pulse, issue a transaction to memory.
- `mem_we` out 1: 1 = write, 0 = read. Valid with `mem_req`.
- `mem_addr` out WORD_SIZE: transaction address.
- `mem_wdata` out LINE_SIZE: write data.
- `mem_ack` in 1: one-cycle pulse, transaction complete. Read data is valid with it.
- `mem_rdata` in LINE_SIZE: read line.

## Operation
- Three pending slots: I-read (flag + addr), D-read (flag + addr), D-write (flag + addr + data).
  - A request sets its slot at the next edge if the slot is empty.
  - A request to an occupied slot is ignored; the first address wins.
  - The caches are responsible for not issuing a second miss per slot.
- FSM, two states:
  - IDLE: if any slot is pending, or being set this cycle (bypass), select a winner. At the edge, drive `mem_req`/`mem_we`/`mem_addr`/`mem_wdata`, record the granted source, clear its slot, and go to BUSY.
  - BUSY: wait for `mem_ack`. On an acked read, register the line on the matching `*_res_data`, return the transaction address on `*_res_addr`, pulse `*_res` for one cycle, then go to IDLE. On an acked write, produce no cache response and go to IDLE.
- Arbitration:
  - Within D, write beats read, so a read of a just-evicted line sees the written data.
  - Between I and D, round-robin on a 1-bit `last_grant` (0 = I, 1 = D, reset 0). When both are pending, grant the one not last granted. A single pending source is granted directly.
- `mem_ack` in IDLE is ignored. `mem_rdata` is ignored for writes.
- Reset clears all slots and `last_grant`, forces IDLE, and drives all outputs to 0.
  - A transaction in flight at reset is abandoned.
  - Its late `mem_ack` arrives in IDLE and is ignored.

## Timing
- Request at cycle 0 with an idle arbiter and empty slots: `mem_req` high in cycle 1.
- `mem_ack` sampled at edge e: `i_res`/`d_res` high in the cycle following e.
- The next `mem_req` rises at the earliest one cycle later. This leaves at least one bubble cycle between transactions.
- End-to-end read latency: memory latency + 2 cycles.
- `mem_req`, `i_res` and `d_res` are registered pulses, exactly 1 cycle wide.
- `mem_addr`, `mem_we` and `mem_wdata` are held stable through BUSY.
- `*_res_data` and `*_res_addr` are held until the next response of the same source.
- A request arriving in the same cycle as `mem_ack` is latched into its slot. It competes in the next IDLE cycle.
- Simultaneous `i_read`, `d_read` and `d_wenable` from IDLE: order is D-write, then I, then D-read.
  - This assumes the I/D round-robin starts at reset (`last_grant`=0): D-write wins first, I second, D-read third.

## Test plan
- Single I read: `i_read` with addr 0x100 at cycle 0; memory acks 3 cycles after `mem_req`.
  - Required: `mem_req` in cycle 1, `mem_we`=0, `mem_addr`=0x100.
  - Required: `i_res` pulse in cycle 5 with `i_res_addr`=0x100 and `mem_rdata` reproduced.
- Write-before-read: `d_wenable` (0x200, data A) and `d_read` (0x200) in the same cycle.
  - Required: write issued first, with no `d_res` for it.
  - Required: read issued after its ack, and `d_res_data` equal to the data returned by memory.
- Fairness: I and D reads held pending continuously for 6 transactions.
  - Required: grants alternate D, I, D, I, D, I starting from reset.
- Ignored duplicate: `i_read` 0x100, then `i_read` 0x140 while the slot is pending or in flight, with no further I requests.
  - Required: exactly one `mem_req`, address 0x100.
- Reset mid-operation: assert `rst` while BUSY, then deliver `mem_ack` after reset is released.
  - Required: all outputs 0 during reset, no `i_res`/`d_res` pulse, and the next request is served normally.
- Stray ack: `mem_ack` pulse in IDLE.
  - Required: no response pulse and no state change.
